// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared widths, depth and entry layout for the store buffer
package store_buffer_pkg;
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 10;
  localparam int SB_DATA_W = 16;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - address compare across buffered stores, youngest entry wins
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [PW-1:0]     tail,
  input  logic [PW:0]       count,
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk from oldest valid slot to youngest so the last match assigned is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PW'(k + 1);
      if (((PW + 1)'(k) < count) && (entry_addr[idx] == address)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO in front of data memory with load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       cpu_address,
  input  logic [DATA_W-1:0]       cpu_write_data,
  input  logic                    cpu_write,
  input  logic                    cpu_read,
  output logic [DATA_W-1:0]       cpu_read_data,
  output logic                    stall,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_read_data
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              drain;
  logic              full;
  logic              accept;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;

  // A load owns the memory port outright; stores only drain on non-load cycles.
  assign drain  = ~cpu_read & (count != '0);
  assign full   = (count == (PW + 1)'(DEPTH));
  assign accept = cpu_write & (~full | drain);
  assign stall  = cpu_write & full & ~drain;
  assign empty  = (count == '0);

  assign mem_read  = cpu_read;
  assign mem_write = drain;

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    if (cpu_read) begin
      mem_address = cpu_address;
    end else if (drain) begin
      mem_address    = buf_addr[head];
      mem_write_data = buf_data[head];
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PW     (PW)
  ) u_match (
    .entry_addr (buf_addr),
    .entry_data (buf_data),
    .tail       (tail),
    .count      (count),
    .address    (cpu_address),
    .hit        (hit),
    .data       (fwd_data)
  );

  assign cpu_read_data = !cpu_read ? '0 : (hit ? fwd_data : mem_read_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // When full and draining, tail equals head; the drain reads the old entry before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_addr[tail] <= cpu_address;
      buf_data[tail] <= cpu_write_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed table-driven bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cpu_address;
  logic [15:0] cpu_write_data;
  logic        cpu_write;
  logic        cpu_read;
  logic [15:0] cpu_read_data;
  logic        stall;
  logic        empty;
  logic [2:0]  count;
  logic [9:0]  mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_read_data;

  logic [15:0] mem [1024];
  logic        leak = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        w;
    logic        r;
    logic [9:0]  a;
    logic [15:0] d;
    logic        e_stall;
    logic [2:0]  e_cnt;
    logic        e_mw;
    logic [9:0]  e_maddr;
    logic [15:0] e_mwd;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  store_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_write      (cpu_write),
    .cpu_read       (cpu_read),
    .cpu_read_data  (cpu_read_data),
    .stall          (stall),
    .empty          (empty),
    .count          (count),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address] <= mem_write_data;
      if (mem_address >= 10'd600 && mem_address <= 10'd602) leak <= 1'b1;
    end
  end

  function automatic logic [15:0] iv(input int a);
    return 16'hC000 + 16'(a);
  endfunction

  function automatic vec_t mk(input logic w, input logic r, input int a, input logic [15:0] d,
                              input logic st, input int cnt, input logic mw, input int maddr,
                              input logic [15:0] mwd, input logic [15:0] rd);
    vec_t v;
    v.w = w; v.r = r; v.a = 10'(a); v.d = d;
    v.e_stall = st; v.e_cnt = 3'(cnt); v.e_mw = mw; v.e_maddr = 10'(maddr);
    v.e_mwd = mwd; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [9:0] a, input logic [15:0] d);
    cpu_write      = w;
    cpu_read       = r;
    cpu_address    = a;
    cpu_write_data = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = iv(i);
    rst = 1'b0;
    drive(1'b1, 1'b1, 10'd5, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", 32'(count), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset mem_read", 32'(mem_read), 32'd1);
    drive(1'b0, 1'b0, 10'd0, 16'h0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 500, 16'h0001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 500, 16'h0001, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 501, 16'h0002, 0, 0, 0, 501, 0, iv(501)));
    vecs.push_back(mk(1, 1, 501, 16'h00AA, 0, 1, 0, 501, 0, 16'h0002));
    vecs.push_back(mk(0, 1, 501, 0, 0, 2, 0, 501, 0, 16'h00AA));
    vecs.push_back(mk(0, 1, 502, 0, 0, 2, 0, 502, 0, iv(502)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 501, 16'h0002, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 501, 16'h00AA, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 503, 16'h0503, 0, 0, 0, 503, 0, iv(503)));
    vecs.push_back(mk(1, 1, 504, 16'h0504, 0, 1, 0, 504, 0, iv(504)));
    vecs.push_back(mk(1, 1, 505, 16'h0505, 0, 2, 0, 505, 0, iv(505)));
    vecs.push_back(mk(1, 1, 506, 16'h0506, 0, 3, 0, 506, 0, iv(506)));
    vecs.push_back(mk(1, 1, 507, 16'h0507, 1, 4, 0, 507, 0, iv(507)));
    vecs.push_back(mk(1, 1, 507, 16'h0507, 1, 4, 0, 507, 0, iv(507)));
    vecs.push_back(mk(1, 0, 507, 16'h0507, 0, 4, 1, 503, 16'h0503, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 504, 16'h0504, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 505, 16'h0505, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 506, 16'h0506, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 507, 16'h0507, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 508, 16'h0009, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 508, 16'h0010, 0, 1, 1, 508, 16'h0009, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 508, 16'h0010, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
      @(negedge clk);
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("row%0d empty", i), 32'(empty), 32'(vecs[i].e_cnt == 3'd0));
      chk($sformatf("row%0d mem_write", i), 32'(mem_write), 32'(vecs[i].e_mw));
      chk($sformatf("row%0d mem_read", i), 32'(mem_read), 32'(vecs[i].r));
      chk($sformatf("row%0d mem_address", i), 32'(mem_address), 32'(vecs[i].e_maddr));
      chk($sformatf("row%0d cpu_read_data", i), 32'(cpu_read_data), 32'(vecs[i].e_rd));
      if (vecs[i].e_mw)
        chk($sformatf("row%0d mem_write_data", i), 32'(mem_write_data), 32'(vecs[i].e_mwd));
      @(posedge clk);
      #1;
    end

    chk("mem[500]", 32'(mem[500]), 32'h0001);
    chk("mem[501]", 32'(mem[501]), 32'h00AA);
    chk("mem[502]", 32'(mem[502]), 32'(iv(502)));
    chk("mem[503]", 32'(mem[503]), 32'h0503);
    chk("mem[507]", 32'(mem[507]), 32'h0507);
    chk("mem[508]", 32'(mem[508]), 32'h0010);

    // Reset asserted between edges with three stores pending.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 10'(600 + k), 16'(16'h0600 + k));
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 10'd0, 16'h0);
    #1;
    chk("midop count before reset", 32'(count), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk("midop count in reset", 32'(count), 32'd0);
    chk("midop empty in reset", 32'(empty), 32'd1);
    chk("midop mem_write in reset", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midop no leak", 32'(leak), 32'd0);
    chk("midop count after", 32'(count), 32'd0);
    chk("midop mem[600]", 32'(mem[600]), 32'(iv(600)));
    chk("midop mem[602]", 32'(mem[602]), 32'(iv(602)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
